acc_requant: RTL and testbench
==============================

// Module: acc_requant
// PURPOSE
//  Downstream of the int8 MAC pipeline: consumes 32-bit accumulator results (valid-only, no stall) and
//  requantizes each one to int8: rounding arithmetic right shift, then zero-point add, then saturation.
//  Results are buffered in a small FIFO and offered on a valid/ready output to the writeback/store stage.
//  Upstream cannot be back-pressured, so a write into a full FIFO is dropped and flagged.
// PARAMETERS
//  ACC_W      32  accumulator input width (signed)
//  OUT_W       8  quantized output width (signed)
//  SHIFT_W     5  width of shift amount (0..31)
//  FIFO_DEPTH  4  output buffer entries; power of two, >=2
// PORTS
//  clk             in   1        clock
//  rst_n           in   1        reset, asynchronous, active-low
//  in_valid        in   1        accumulator result valid (from MAC out_valid)
//  in_data         in   ACC_W    signed accumulator result (from MAC y)
//  cfg_shift       in   SHIFT_W  right-shift amount, sampled with each in_valid beat
//  cfg_zero_point  in   OUT_W    signed output zero point, sampled with each in_valid beat
//  out_valid       out  1        FIFO non-empty
//  out_ready       in   1        consumer accepts out_data this cycle
//  out_data        out  OUT_W    signed quantized result (FIFO head)
//  out_sat         out  1        head result was clipped by saturation
//  fill_level      out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
//  overflow        out  1        sticky: a result was dropped on full FIFO
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, out_sat=0, fill_level=0, overflow=0, pipeline valids=0; FIFO emptied.
//    Reset mid-operation discards all in-flight and buffered data.
//  - S1 (edge 1): capture in_data, cfg_shift, cfg_zero_point, in_valid.
//    r = (shift==0) ? x : (x + (1<<<(shift-1))) >>> shift.
//    Computed at ACC_W+1 bits so the rounding add cannot wrap; round half toward +inf.
//  - S2 (edge 2): z = r + zero_point (sign-extended, ACC_W+2 bits).
//    q = clamp(z, -2^(OUT_W-1), 2^(OUT_W-1)-1); sat = (q != z).
//  - Edge 3: {q,sat} written to FIFO if S2 valid. Empty FIFO: out_valid high 3 cycles after in_valid sampled.
//  - Throughput one result/cycle; back-to-back in_valid fully supported; cfg may change every beat.
//  - Pop when out_valid && out_ready. out_data/out_sat hold stable while out_valid && !out_ready.
//  - Push and pop on the same edge:
//    . non-empty FIFO: both occur, level unchanged.
//    . full FIFO: write accepted because pop frees a slot; overflow not set.
//    . empty FIFO: only the push (no head to pop).
//  - Push on full without pop: result dropped, FIFO unchanged, overflow<=1 and held until reset.
//  - Pointers wrap modulo FIFO_DEPTH; full/empty derived from fill_level.
// CONFIGURATION
//  ACC_REQUANT_RELU_EN defined: S2 lower clamp bound becomes max(zero_point, -2^(OUT_W-1)), i.e. fused ReLU.
//    sat is NOT set when the ReLU bound clips.
//  ACC_REQUANT_RELU_EN undefined: symmetric saturation only, as above.
// STRUCTURE
//  - Shared package toy_accel_pkg:
//    . ACC_W and OUT_W constants.
//    . typedefs acc_t (logic signed [ACC_W-1:0]) and q8_t (logic signed [OUT_W-1:0]).
//    . struct requant_cfg_t {shift, zero_point}.
//    . function sat_clip().
//  - One sub-module: acc_requant_fifo, a synchronous show-ahead FIFO with fill count.
//    Width OUT_W+1 (stores {q,sat}). Pipeline S1/S2 stays in the top module.
// TESTING
//  1 in=1000, shift=4, zp=0            -> out_data=63 (1000+8=1008>>>4), sat=0, out_valid 3 cycles later.
//  2 in=-1000, shift=4, zp=0           -> -62 ((-1000+8)>>>4), sat=0.
//    in=-8, shift=4                    -> 0 (round half up).
//  3 in=100000, shift=0, zp=0          -> 127, sat=1.
//    in=-100000                        -> -128, sat=1.
//    in=0x7FFFFFFF, shift=31           -> 1, no wrap.
//  4 out_ready=0, 6 back-to-back beats (depth 4):
//      fill_level reaches 4, overflow=1.
//      First 4 results drain in order once out_ready=1.
//  5 FIFO full, out_ready=1 and new beat arriving every cycle:
//      level stays 4, overflow stays 0, no loss.
//  6 ACC_REQUANT_RELU_EN defined, in=-50, shift=0, zp=-3:
//      -> -3, sat=0.
//    Undefined, same stimulus               -> -53.
//    Assert rst_n mid-stream                -> out_valid=0, fill_level=0 next cycle.

Source files
------------

// File: rtl/toy_accel_pkg.sv
// Shared types for the toy accelerator datapath: accumulator/int8 types,
// requantization config struct and the output clamp helper.
`timescale 1ns/1ps
package toy_accel_pkg;

    localparam int ACC_W   = 32;
    localparam int OUT_W   = 8;
    localparam int SHIFT_W = 5;
    localparam int Z_W     = ACC_W + 2;

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic signed [OUT_W-1:0] q8_t;
    typedef logic signed [Z_W-1:0]   wide_t;

    typedef struct packed {
        logic [SHIFT_W-1:0] shift;
        q8_t                zero_point;
    } requant_cfg_t;

    typedef struct packed {
        q8_t  q;
        logic sat;
    } qres_t;

    localparam wide_t Q_MAX = {{(Z_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam wide_t Q_MIN = {{(Z_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [SHIFT_W-1:0] SHIFT_ONE = {{(SHIFT_W-1){1'b0}}, 1'b1};

    // Clamp z into [lo, Q_MAX]; lo_sat selects whether clipping at lo counts as saturation.
    function automatic qres_t sat_clip(input wide_t z, input wide_t lo, input logic lo_sat);
        qres_t res;
        if (z > Q_MAX) begin
            res.q   = Q_MAX[OUT_W-1:0];
            res.sat = 1'b1;
        end else if (z < lo) begin
            res.q   = lo[OUT_W-1:0];
            res.sat = lo_sat;
        end else begin
            res.q   = z[OUT_W-1:0];
            res.sat = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/acc_requant_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; a push on full is
// accepted only when a pop frees a slot on the same edge.
`timescale 1ns/1ps
module acc_requant_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1'b1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic             valid_r;
    logic             full_s;
    logic             push_s;
    logic             pop_s;
    logic [LVL_W-1:0] level_nxt_s;

    // Push/pop qualification and next occupancy.
    always_comb begin
        full_s = (level_r == LVL_FULL);
        pop_s  = rd_en && valid_r;
        push_s = wr_en && (!full_s || pop_s);
        if (push_s && !pop_s) begin
            level_nxt_s = level_r + LVL_ONE;
        end else if (pop_s && !push_s) begin
            level_nxt_s = level_r - LVL_ONE;
        end else begin
            level_nxt_s = level_r;
        end
    end

    // Storage, pointers and occupancy; pointers wrap naturally at a power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
            valid_r  <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            level_r <= level_nxt_s;
            valid_r <= (level_nxt_s != {LVL_W{1'b0}});
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign valid   = valid_r;
    assign full    = full_s;
    assign level   = level_r;

endmodule

// File: rtl/acc_requant.sv
// Requantizes 32-bit accumulators to int8 (round, zero-point, clamp) into an output FIFO.
// Define ACC_REQUANT_RELU_EN to raise the lower clamp bound to the zero point (fused ReLU).
`timescale 1ns/1ps
module acc_requant
    import toy_accel_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic signed [ACC_W-1:0]       in_data,
    input  logic        [SHIFT_W-1:0]     cfg_shift,
    input  logic signed [OUT_W-1:0]       cfg_zero_point,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [OUT_W-1:0]       out_data,
    output logic                          out_sat,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic                          overflow
);

    localparam logic signed [ACC_W:0] ONE_W = {{ACC_W{1'b0}}, 1'b1};

    logic                    s1_valid_r;
    acc_t                    s1_x_r;
    requant_cfg_t            s1_cfg_r;
    logic signed [ACC_W:0]   x_ext_s;
    logic signed [ACC_W:0]   round_s;
    logic signed [ACC_W:0]   r_s;

    logic                    s2_valid_r;
    logic signed [ACC_W:0]   s2_r_r;
    q8_t                     s2_zp_r;
    wide_t                   z_s;
    wide_t                   lo_s;
    logic                    lo_sat_s;
    qres_t                   res_s;

    logic [OUT_W:0]          head_s;
    logic                    fifo_full_s;
    logic                    ovf_r;

    // Stage 1 capture of the accumulator beat and its config.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_x_r     <= {ACC_W{1'b0}};
            s1_cfg_r   <= {(SHIFT_W+OUT_W){1'b0}};
        end else begin
            s1_valid_r <= in_valid;
            s1_x_r     <= in_data;
            s1_cfg_r   <= '{shift: cfg_shift, zero_point: cfg_zero_point};
        end
    end

    // Rounding right shift, one bit wider so adding the half-LSB never wraps.
    always_comb begin
        x_ext_s = {s1_x_r[ACC_W-1], s1_x_r};
        if (s1_cfg_r.shift == {SHIFT_W{1'b0}}) begin
            round_s = x_ext_s;
        end else begin
            round_s = x_ext_s + (ONE_W <<< (s1_cfg_r.shift - SHIFT_ONE));
        end
        r_s = round_s >>> s1_cfg_r.shift;
    end

    // Stage 2 capture of the shifted value and the zero point that travelled with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            s2_r_r     <= {(ACC_W+1){1'b0}};
            s2_zp_r    <= {OUT_W{1'b0}};
        end else begin
            s2_valid_r <= s1_valid_r;
            s2_r_r     <= r_s;
            s2_zp_r    <= s1_cfg_r.zero_point;
        end
    end

    // Zero-point add and clamp; the ReLU bound clips without flagging saturation.
    always_comb begin
        z_s = {s2_r_r[ACC_W], s2_r_r} + {{(Z_W-OUT_W){s2_zp_r[OUT_W-1]}}, s2_zp_r};
`ifdef ACC_REQUANT_RELU_EN
        lo_s     = {{(Z_W-OUT_W){s2_zp_r[OUT_W-1]}}, s2_zp_r};
        lo_sat_s = 1'b0;
`else
        lo_s     = Q_MIN;
        lo_sat_s = 1'b1;
`endif
        res_s = sat_clip(z_s, lo_s, lo_sat_s);
    end

    acc_requant_fifo #(
        .WIDTH (OUT_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (s2_valid_r),
        .wr_data (res_s),
        .rd_en   (out_ready),
        .rd_data (head_s),
        .valid   (out_valid),
        .full    (fifo_full_s),
        .level   (fill_level)
    );

    // Sticky drop flag: a result arrived on a full FIFO with no pop to make room.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r | (s2_valid_r & fifo_full_s & ~(out_valid & out_ready));
        end
    end

    assign out_data = head_s[OUT_W:1];
    assign out_sat  = head_s[0];
    assign overflow = ovf_r;

endmodule

// File: tb/tb_acc_requant.sv
// Scoreboard bench for acc_requant: arithmetic reference model feeds an
// expected FIFO queue; a negedge monitor compares the DUT head against it.
`timescale 1ns/1ps
module tb_acc_requant;
    import toy_accel_pkg::*;

    localparam int DEPTH = 4;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic                        in_valid = 1'b0;
    logic signed [31:0]          in_data = 32'sd0;
    logic [4:0]                  cfg_shift = 5'd0;
    logic signed [7:0]           cfg_zero_point = 8'sd0;
    logic                        out_ready = 1'b0;
    logic                        out_valid;
    logic signed [7:0]           out_data;
    logic                        out_sat;
    logic [$clog2(DEPTH):0]      fill_level;
    logic                        overflow;

    int n_cmp = 0;
    int n_err = 0;

    logic [8:0] mq[$];
    logic       st1_v = 1'b0, st2_v = 1'b0;
    logic [8:0] st1_d = 9'd0, st2_d = 9'd0;
    logic       ovf_m = 1'b0;

    always #5 clk = ~clk;

    acc_requant #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .cfg_shift(cfg_shift), .cfg_zero_point(cfg_zero_point),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat(out_sat), .fill_level(fill_level), .overflow(overflow)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: round-half-up division by 2^sh, add zero point, clamp to int8.
    function automatic logic [8:0] ref_q(input int x, input int sh, input int zp);
        longint r;
        longint z;
        logic [7:0] qb;
        if (sh == 0) r = x;
        else r = (longint'(x) + (longint'(1) << (sh - 1))) >>> sh;
        z = r + zp;
`ifdef ACC_REQUANT_RELU_EN
        if (z < zp) begin
            qb = zp[7:0];
            return {qb, 1'b0};
        end
`endif
        if (z > 127) return {8'd127, 1'b1};
        if (z < -128) return {8'h80, 1'b1};
        qb = z[7:0];
        return {qb, 1'b0};
    endfunction

    // Model: results reach the buffer two edges after the edge that samples them.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            st1_v <= 1'b0;
            st2_v <= 1'b0;
            ovf_m <= 1'b0;
        end else begin
            bit pop;
            bit was_full;
            was_full = (mq.size() == DEPTH);
            pop = out_ready && (mq.size() != 0);
            if (pop) void'(mq.pop_front());
            if (st2_v) begin
                if (!was_full || pop) mq.push_back(st2_d);
                else ovf_m <= 1'b1;
            end
            st2_v <= st1_v;
            st2_d <= st1_d;
            st1_v <= in_valid;
            st1_d <= ref_q(in_data, int'(cfg_shift), int'(cfg_zero_point));
        end
    end

    // Monitor: compare DUT status and head against the expected queue.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", int'(out_valid), int'(mq.size() != 0));
            chk("fill_level", int'(fill_level), mq.size());
            chk("overflow", int'(overflow), int'(ovf_m));
            if (out_valid && mq.size() != 0)
                chk("head_q_sat", int'({out_data, out_sat}), int'(mq[0]));
        end
    end

    task automatic drive(input int x, input int sh, input int zp);
        in_valid = 1'b1;
        in_data = x;
        cfg_shift = sh[4:0];
        cfg_zero_point = zp[7:0];
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_fill_level", int'(fill_level), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_sat", int'(out_sat), 0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int x;
        int budget;
        repeat (2) @(negedge clk);
        do_reset();
        out_ready = 1'b1;

        // Latency and the reference vectors
        drive(1000, 4, 0);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 3);
        chk("t1_data", int'(out_data), 63);
        chk("t1_sat", int'(out_sat), 0);
        idle(2);
        drive(-1000, 4, 0);
        drive(-8, 4, 0);
        drive(100000, 0, 0);
        drive(-100000, 0, 0);
        drive(32'h7FFFFFFF, 31, 0);
        drive(-50, 0, -3);
        drive(32'h80000000, 31, 127);
        drive(200, 3, -128);
        idle(6);

        // Overflow on a stalled consumer, then in-order drain
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) drive(i * 37 - 90, 0, 0);
        idle(4);
        chk("t4_level", int'(fill_level), 4);
        chk("t4_overflow", int'(overflow), 1);
        out_ready = 1'b1;
        idle(6);
        do_reset();

        // Full FIFO with simultaneous pop and push every cycle
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) drive(i * 16, 2, 5);
        idle(3);
        for (int i = 0; i < 10; i++) begin
            if (i == 2) out_ready = 1'b1;
            if (i >= 3) begin
                chk("t5_level", int'(fill_level), 4);
                chk("t5_overflow", int'(overflow), 0);
            end
            drive($urandom_range(0, 4000) - 2000, $urandom_range(0, 8), $urandom_range(0, 20) - 10);
        end
        idle(8);

        // Randomized traffic with a reset mid-stream
        for (int c = 0; c < 400; c++) begin
            if (c == 200) begin
                in_valid = 1'b0;
                rst_n = 1'b0;
                #1;
                chk("midrst_out_valid", int'(out_valid), 0);
                chk("midrst_fill_level", int'(fill_level), 0);
                @(negedge clk);
                rst_n = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 2))
                0: x = $urandom;
                1: x = $urandom_range(0, 2000) - 1000;
                default: x = $urandom_range(0, 400000) - 200000;
            endcase
            in_valid = ($urandom_range(0, 3) != 0);
            in_data = x;
            cfg_shift = 5'($urandom_range(0, 31));
            cfg_zero_point = 8'($urandom);
            @(negedge clk);
        end

        in_valid = 1'b0;
        out_ready = 1'b1;
        budget = 0;
        while ((mq.size() != 0 || out_valid) && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        chk("drain_empty", mq.size() + int'(out_valid), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
